lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Sequencing controller for the 16x2 character LCD; sits directly upstream of the LCD datapath (`lcd_dp`) and owns every select line it consumes. After power-up it issues the four-command init sequence, then repeatedly writes the second-line DDRAM address (0xC0) followed by 16 character bytes, generating RS/RW/E with HD44780 setup, pulse and settle timing. Counter values feeding the datapath are sampled character-by-character as `mux_sel` steps 0..15.

## Interface
- PWRUP_CYC, 750000 — power-up wait in clocks (15 ms @ 50 MHz)
- E_HIGH_CYC, 12 — E pulse width in clocks (≥230 ns)
- CMD_WAIT_CYC, 2000 — post-E settle for normal commands/data (40 µs)
- CLR_WAIT_CYC, 82000 — post-E settle for the clear command (1.64 ms)
- REFRESH_CYC, 2500000 — idle gap between frames (50 ms)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- hold  in  1  when high, controller stops at the next frame boundary and stays idle
- reinit  in  1  single-cycle request to rerun the init sequence (see Configuration)
- init_set  out  2  init command index to datapath
- mux_sel  out  4  character index to datapath
- data_sel  out  1  0 = init command, 1 = character byte
- DB_sel  out  1  0 = address byte 0xC0, 1 = `data_sel` path
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0 (write only)
- lcd_e  out  1  LCD enable strobe
- frame_done  out  1  one-cycle pulse after character 15 settles
- init_done  out  1  high once the init sequence has completed

## Operation
- Reset: all outputs 0, state PWRUP, all counters 0. Async assert takes effect immediately, including mid-pulse (E drops to 0).
- States: PWRUP → INIT → ADDR → CHAR → GAP → ADDR ...
- PWRUP: wait PWRUP_CYC clocks, E=0.
- Each bus write is three phases: SETUP (1 clock, selects/RS stable, E=0), PULSE (E=1 for E_HIGH_CYC clocks), SETTLE (E=0 for CMD_WAIT_CYC, or CLR_WAIT_CYC when init_set=3). Selects and RS are held constant across all three phases.
- INIT: 4 writes, init_set=0,1,2,3 (index 3 = clear display), RS=0, data_sel=0, DB_sel=1. After last settle, init_done=1.
- ADDR: one write, DB_sel=0 (0xC0), RS=0.
- CHAR: 16 writes, mux_sel=0..15, RS=1, data_sel=1, DB_sel=1. mux_sel increments only at a SETTLE→SETUP transition; wraps 15→0 on leaving CHAR.
- frame_done pulses the clock after character 15 SETTLE ends; state → GAP.
- GAP: wait REFRESH_CYC clocks; then if hold=0 → ADDR, else remain in GAP until hold=0 (gap not restarted).
- hold asserted mid-frame has no effect until GAP.
- Outside INIT, init_set holds 3; outside CHAR, mux_sel holds 0.

## Timing
- First E rise: PWRUP_CYC+1 clocks after rst_n deassert.
- Write period: 1+E_HIGH_CYC+CMD_WAIT_CYC clocks (clear: CLR_WAIT_CYC instead).
- Init duration: 3·(1+E_HIGH_CYC+CMD_WAIT_CYC)+(1+E_HIGH_CYC+CLR_WAIT_CYC).
- Frame (ADDR+CHAR): 17·(1+E_HIGH_CYC+CMD_WAIT_CYC); frame_done one clock later.
- All outputs registered; no combinational path from hold/reinit to outputs.
- Counters sized for the largest parameter (≥23 bits at defaults); no overflow at any legal setting.

## Configuration
- LCD_CTRL_REINIT_EN defined: `reinit` high in any state except PWRUP is latched; at the end of the current write (or immediately in GAP) the controller enters INIT at init_set=0, clears init_done, skips power-up wait. reinit during INIT restarts from index 0 after the current write.
- Not defined: `reinit` ignored; init runs only after reset.

## Test plan
Params PWRUP_CYC=10, E_HIGH_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8, REFRESH_CYC=5.
- Reset release → E first high at clock 11, init_set=0, RS=0; four E pulses with init_set 0..3, init_done high at clock 43; clear's settle is 8 clocks.
- After init → one E pulse with DB_sel=0, RS=0, then 16 pulses RS=1 with mux_sel 0..15, each 7 clocks apart; frame_done single pulse 120 clocks after ADDR SETUP.
- hold=1 asserted during char 5 → frame finishes, GAP entered, no further E; hold=0 → ADDR SETUP next clock.
- rst_n pulsed low during an E pulse in CHAR → E, RS, selects 0 immediately; restart repeats full PWRUP+init timing.
- With LCD_CTRL_REINIT_EN, reinit in GAP → next write has init_set=0, init_done=0; without macro, same stimulus → ADDR write after gap.
- Check lcd_rw=0 and selects stable throughout every E high phase (assertion).

Source files
------------

// File: rtl/lcd_ctrl_if.sv
// Select/strobe bundle between lcd_ctrl (master) and the LCD datapath and pins (slave).
// hold/reinit flow into the controller; everything else flows out of it.
interface lcd_ctrl_if;
  logic       hold;
  logic       reinit;
  logic [1:0] init_set;
  logic [3:0] mux_sel;
  logic       data_sel;
  logic       DB_sel;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       frame_done;
  logic       init_done;

  modport master (
    input  hold, reinit,
    output init_set, mux_sel, data_sel, DB_sel,
    output lcd_rs, lcd_rw, lcd_e, frame_done, init_done
  );

  modport slave (
    output hold, reinit,
    input  init_set, mux_sel, data_sel, DB_sel,
    input  lcd_rs, lcd_rw, lcd_e, frame_done, init_done
  );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 16x2 sequencer: power-up wait, 4-command init, then 0xC0 + 16 chars per frame.
// Optional LCD_CTRL_REINIT_EN: honour the reinit request to rerun init without power-up wait.
module lcd_ctrl #(
  parameter int PWRUP_CYC    = 750000,
  parameter int E_HIGH_CYC   = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int REFRESH_CYC  = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  lcd_ctrl_if.master bus
);

  localparam int MAX_A   = (PWRUP_CYC > REFRESH_CYC) ? PWRUP_CYC : REFRESH_CYC;
  localparam int MAX_B   = (CLR_WAIT_CYC > CMD_WAIT_CYC) ? CLR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > E_HIGH_CYC) ? MAX_C : E_HIGH_CYC;
  // One spare bit so the terminal compare never sits at the top of the range.
  localparam int CNT_W   = $clog2(MAX_CYC + 1) + 1;

  typedef enum logic [2:0] {ST_PWRUP, ST_INIT, ST_ADDR, ST_CHAR, ST_GAP} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_SETTLE} phase_t;

  state_t           state_reg;
  phase_t           phase_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       init_set_reg;
  logic [3:0]       mux_sel_reg;
  logic             data_sel_reg;
  logic             db_sel_reg;
  logic             rs_reg;
  logic             e_reg;
  logic             init_end_reg;
  logic             frame_end_reg;
  logic             init_done_reg;
  logic             frame_done_reg;

  logic [CNT_W-1:0] settle_last;
  logic             settle_end;
  logic             reinit_req;
  logic             take_reinit;

  assign settle_last = (state_reg == ST_INIT && init_set_reg == 2'd3)
                     ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
  assign settle_end  = (phase_reg == PH_SETTLE) && (cnt_reg == settle_last);

`ifdef LCD_CTRL_REINIT_EN
  logic reinit_pend_reg;

  assign reinit_req = reinit_pend_reg | (bus.reinit & (state_reg != ST_PWRUP));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reinit_pend_reg <= 1'b0;
    end else if (take_reinit) begin
      reinit_pend_reg <= 1'b0;
    end else if (reinit_req) begin
      reinit_pend_reg <= 1'b1;
    end
  end
`else
  logic unused_reinit;
  assign unused_reinit = bus.reinit;
  assign reinit_req    = 1'b0;
`endif

  // Reinit is only taken on a write boundary so an in-flight E pulse is never cut short.
  assign take_reinit = reinit_req &
                       ((state_reg == ST_GAP) | ((state_reg != ST_PWRUP) & settle_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_PWRUP;
      phase_reg      <= PH_SETUP;
      cnt_reg        <= '0;
      init_set_reg   <= 2'd0;
      mux_sel_reg    <= 4'd0;
      data_sel_reg   <= 1'b0;
      db_sel_reg     <= 1'b0;
      rs_reg         <= 1'b0;
      e_reg          <= 1'b0;
      init_end_reg   <= 1'b0;
      frame_end_reg  <= 1'b0;
      init_done_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      init_end_reg   <= 1'b0;
      frame_end_reg  <= 1'b0;
      frame_done_reg <= frame_end_reg;
      if (init_end_reg) begin
        init_done_reg <= 1'b1;
      end

      if (take_reinit) begin
        state_reg     <= ST_INIT;
        phase_reg     <= PH_SETUP;
        cnt_reg       <= '0;
        e_reg         <= 1'b0;
        init_set_reg  <= 2'd0;
        mux_sel_reg   <= 4'd0;
        data_sel_reg  <= 1'b0;
        db_sel_reg    <= 1'b1;
        rs_reg        <= 1'b0;
        init_done_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_PWRUP: begin
            if (cnt_reg == CNT_W'(PWRUP_CYC - 1)) begin
              state_reg    <= ST_INIT;
              phase_reg    <= PH_SETUP;
              cnt_reg      <= '0;
              init_set_reg <= 2'd0;
              data_sel_reg <= 1'b0;
              db_sel_reg   <= 1'b1;
              rs_reg       <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end

          // The gap counter saturates so a long hold does not restart the refresh wait.
          ST_GAP: begin
            if (cnt_reg == CNT_W'(REFRESH_CYC - 1)) begin
              if (!bus.hold) begin
                state_reg    <= ST_ADDR;
                phase_reg    <= PH_SETUP;
                cnt_reg      <= '0;
                data_sel_reg <= 1'b0;
                db_sel_reg   <= 1'b0;
                rs_reg       <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end

          default: begin
            case (phase_reg)
              PH_SETUP: begin
                phase_reg <= PH_PULSE;
                e_reg     <= 1'b1;
                cnt_reg   <= '0;
              end

              PH_PULSE: begin
                if (cnt_reg == CNT_W'(E_HIGH_CYC - 1)) begin
                  phase_reg <= PH_SETTLE;
                  e_reg     <= 1'b0;
                  cnt_reg   <= '0;
                end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                end
              end

              default: begin
                if (settle_end) begin
                  cnt_reg   <= '0;
                  phase_reg <= PH_SETUP;
                  // Selects only move here, between writes, never inside one.
                  case (state_reg)
                    ST_INIT: begin
                      if (init_set_reg == 2'd3) begin
                        state_reg    <= ST_ADDR;
                        data_sel_reg <= 1'b0;
                        db_sel_reg   <= 1'b0;
                        rs_reg       <= 1'b0;
                        init_end_reg <= 1'b1;
                      end else begin
                        init_set_reg <= init_set_reg + 2'd1;
                      end
                    end
                    ST_ADDR: begin
                      state_reg    <= ST_CHAR;
                      mux_sel_reg  <= 4'd0;
                      data_sel_reg <= 1'b1;
                      db_sel_reg   <= 1'b1;
                      rs_reg       <= 1'b1;
                    end
                    default: begin
                      if (mux_sel_reg == 4'd15) begin
                        state_reg     <= ST_GAP;
                        mux_sel_reg   <= 4'd0;
                        data_sel_reg  <= 1'b0;
                        db_sel_reg    <= 1'b0;
                        rs_reg        <= 1'b0;
                        frame_end_reg <= 1'b1;
                      end else begin
                        mux_sel_reg <= mux_sel_reg + 4'd1;
                      end
                    end
                  endcase
                end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  assign bus.init_set   = init_set_reg;
  assign bus.mux_sel    = mux_sel_reg;
  assign bus.data_sel   = data_sel_reg;
  assign bus.DB_sel     = db_sel_reg;
  assign bus.lcd_rs     = rs_reg;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = e_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.init_done  = init_done_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: expected bus writes queued from a table, compared at each E rise.
module tb_lcd_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .PWRUP_CYC   (10),
    .E_HIGH_CYC  (2),
    .CMD_WAIT_CYC(4),
    .CLR_WAIT_CYC(8),
    .REFRESH_CYC (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] iset;
    logic [3:0] mux;
    logic       dsel;
    logic       dbsel;
    logic       rs;
  } wr_t;

  wr_t tbl [21];
  wr_t wq [$];
  int  fdq [$];
  int  idq [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic e_prev = 1'b0;
  logic id_prev = 1'b0;
  logic [8:0] cap_sel = '0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end else begin
      $display("ok   %s at cyc %0d: %0d", name, cyc, act);
    end
  endtask

  // Rows 0..3 offset from INIT setup, rows 4..20 offset from ADDR setup.
  task automatic push_rows(input int first, input int last, input int base);
    for (int i = first; i <= last; i++) begin
      wr_t w;
      w = tbl[i];
      w.cyc = base + tbl[i].cyc;
      wq.push_back(w);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) chk("timeout_wait", cyc, n);
  endtask

  function automatic logic [8:0] sel_vec();
    return {bus.init_set, bus.mux_sel, bus.data_sel, bus.DB_sel, bus.lcd_rs};
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cyc = 0;
      e_prev = 1'b0;
      id_prev = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (bus.lcd_e && !e_prev) begin
        if (wq.size() == 0) begin
          chk("unexpected_e", 1, 0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("e_rise_cyc", cyc, w.cyc);
          chk("init_set", int'(bus.init_set), int'(w.iset));
          chk("mux_sel", int'(bus.mux_sel), int'(w.mux));
          chk("data_sel", int'(bus.data_sel), int'(w.dsel));
          chk("DB_sel", int'(bus.DB_sel), int'(w.dbsel));
          chk("lcd_rs", int'(bus.lcd_rs), int'(w.rs));
          chk("lcd_rw", int'(bus.lcd_rw), 0);
        end
        cap_sel = sel_vec();
      end else if (bus.lcd_e) begin
        chk("sel_stable_e_high", int'(sel_vec()), int'(cap_sel));
        chk("lcd_rw_e_high", int'(bus.lcd_rw), 0);
      end
      if (bus.frame_done) begin
        if (fdq.size() == 0) chk("unexpected_frame_done", 1, 0);
        else chk("frame_done_cyc", cyc, fdq.pop_front());
      end
      if (bus.init_done && !id_prev) begin
        if (idq.size() == 0) chk("unexpected_init_done", 1, 0);
        else chk("init_done_cyc", cyc, idq.pop_front());
      end
      e_prev = bus.lcd_e;
      id_prev = bus.init_done;
    end
  end

  task automatic push_boot();
    push_rows(0, 3, 10);
    push_rows(4, 20, 42);
    fdq.push_back(162);
    idq.push_back(43);
  endtask

  initial begin
    int guard;
    for (int k = 0; k < 4; k++)
      tbl[k] = '{cyc: 1 + 7 * k, iset: 2'(k), mux: 4'd0, dsel: 1'b0, dbsel: 1'b1, rs: 1'b0};
    tbl[4] = '{cyc: 1, iset: 2'd3, mux: 4'd0, dsel: 1'b0, dbsel: 1'b0, rs: 1'b0};
    for (int j = 0; j < 16; j++)
      tbl[5 + j] = '{cyc: 8 + 7 * j, iset: 2'd3, mux: 4'(j), dsel: 1'b1, dbsel: 1'b1, rs: 1'b1};

    bus.hold = 1'b0;
    bus.reinit = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_e", int'(bus.lcd_e), 0);
    chk("rst_sel", int'(sel_vec()), 0);
    chk("rst_done", int'({bus.frame_done, bus.init_done}), 0);
    chk("rst_rw", int'(bus.lcd_rw), 0);

    // Boot: power-up, init, first frame; hold raised during char 5.
    push_boot();
    rst_n = 1'b1;
    wait_cyc(86);
    bus.hold = 1'b1;
    wait_cyc(200);
    chk("gap_idle_e", int'(bus.lcd_e), 0);
    chk("gap_queue_drained", wq.size(), 0);
    bus.hold = 1'b0;
    push_rows(4, 20, 201);
    fdq.push_back(321);
    wait_cyc(201);
    chk("addr_setup_db_sel", int'(bus.DB_sel), 0);
    chk("addr_setup_rs", int'(bus.lcd_rs), 0);
    chk("addr_setup_e", int'(bus.lcd_e), 0);

    // Async reset in the middle of char 3's E pulse.
    wait_cyc(230);
    chk("pre_rst_e_high", int'(bus.lcd_e), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_e", int'(bus.lcd_e), 0);
    chk("midrst_sel", int'(sel_vec()), 0);
    chk("midrst_done", int'({bus.frame_done, bus.init_done}), 0);
    wq.delete();
    fdq.delete();
    idq.delete();
    repeat (2) @(negedge clk);
    push_boot();
    rst_n = 1'b1;

    // Reinit request during the gap after the first frame.
    wait_cyc(163);
    bus.reinit = 1'b1;
    @(negedge clk);
    bus.reinit = 1'b0;
`ifdef LCD_CTRL_REINIT_EN
    push_rows(0, 3, 164);
    push_rows(4, 4, 196);
    idq.push_back(197);
    chk("reinit_init_done_clr", int'(bus.init_done), 0);
    chk("reinit_init_set", int'(bus.init_set), 0);
`else
    push_rows(4, 7, 166);
    chk("noreinit_init_done", int'(bus.init_done), 1);
    chk("noreinit_init_set", int'(bus.init_set), 3);
`endif

    guard = 0;
    while (wq.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("final_wq_left", wq.size(), 0);
    chk("final_fdq_left", fdq.size(), 0);
    chk("final_idq_left", idq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
